cla_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 34 +++
 rtl/cla_group.sv | 34 +++
 rtl/cla_adder.sv | 66 ++++++
 tb/tb_cla_adder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and the expanded-form carry lookahead function used at both
// the bit level (inside a group) and the group level (across groups).
package cla_pkg;

    localparam int unsigned CLA_GROUP = 4;
    // Widest (g, p) vector the lookahead function accepts; callers zero-extend.
    localparam int unsigned CLA_MAX   = 64;
    localparam int unsigned CLA_IDX_W = 6;

    // Carry into position k in two-level sum-of-products form:
    //   c[k] = OR_j<k ( g[j] & p[j+1] & ... & p[k-1] )  |  cin & p[0] & ... & p[k-1]
    // k is a constant at every call site, so this flattens to pure lookahead logic.
    function automatic logic lookahead_carry(input logic [CLA_MAX-1:0] g,
                                             input logic [CLA_MAX-1:0] p,
                                             input logic               cin,
                                             input int unsigned        k);
        logic carry;
        logic term;
        carry = 1'b0;
        for (int unsigned j = 0; j < k; j++) begin
            term = g[j[CLA_IDX_W-1:0]];
            for (int unsigned m = j + 1; m < k; m++) begin
                term = term & p[m[CLA_IDX_W-1:0]];
            end
            carry = carry | term;
        end
        term = cin;
        for (int unsigned m = 0; m < k; m++) begin
            term = term & p[m[CLA_IDX_W-1:0]];
        end
        return carry | term;
    endfunction

endpackage

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead block: sum plus group generate/propagate so the
// parent can compute inter-group carries without waiting on this group's cout.
module cla_group
    import cla_pkg::*;
#(
    parameter int unsigned GROUP = CLA_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             gen,
    output logic             prop,
    output logic             cout
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar i = 0; i <= GROUP; i++) begin : g_carry
        assign c[i] = lookahead_carry(CLA_MAX'(g), CLA_MAX'(p), cin, i);
    end

    assign sum  = p ^ c[GROUP-1:0];
    assign cout = c[GROUP];
    // Group generate is the group carry-out with a zero carry-in.
    assign gen  = lookahead_carry(CLA_MAX'(g), CLA_MAX'(p), 1'b0, GROUP);
    assign prop = &p;

endmodule

// File: rtl/cla_adder.sv
// Registered two-level carry-lookahead adder: WIDTH/GROUP lookahead groups, a
// group-level lookahead unit for the inter-group carries, and an output register.
module cla_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int unsigned NumGroups = WIDTH / GROUP;

    if (GROUP == 0 || WIDTH == 0 || (WIDTH % GROUP) != 0 || GROUP >= CLA_MAX ||
        NumGroups >= CLA_MAX) begin : g_bad_params
        $error("cla_adder: WIDTH must be a positive multiple of GROUP within lookahead limits");
    end

    logic [NumGroups-1:0] grp_gen;
    logic [NumGroups-1:0] grp_prop;
    logic [NumGroups-1:0] grp_cout;
    logic [NumGroups:0]   grp_carry;
    logic [WIDTH-1:0]     sum_d;
    logic                 c_out_d;

    for (genvar k = 0; k < NumGroups; k++) begin : g_group
        cla_group #(
            .GROUP (GROUP)
        ) u_group (
            .a    (a[k*GROUP +: GROUP]),
            .b    (b[k*GROUP +: GROUP]),
            .cin  (grp_carry[k]),
            .sum  (sum_d[k*GROUP +: GROUP]),
            .gen  (grp_gen[k]),
            .prop (grp_prop[k]),
            .cout (grp_cout[k])
        );
    end

    // Second-level lookahead over (G, P); adder carry-in is tied to zero.
    for (genvar k = 0; k <= NumGroups; k++) begin : g_grp_carry
        assign grp_carry[k] = lookahead_carry(CLA_MAX'(grp_gen), CLA_MAX'(grp_prop), 1'b0, k);
    end

    assign c_out_d = grp_carry[NumGroups];

    // Group ripple carries are superseded by the lookahead unit.
    logic unused_cout;
    assign unused_cout = ^grp_cout;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum   <= '0;
            c_out <= 1'b0;
        end else begin
            sum   <= sum_d;
            c_out <= c_out_d;
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Bench for cla_adder: a 4-bit and a 16-bit instance driven in lockstep, with
// expected results queued at drive time and checked one edge later.
module tb_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  a4, b4, sum4;
    logic        c4;
    logic [15:0] a16, b16, sum16;
    logic        c16;

    always #5 clk = ~clk;

    cla_adder #(.WIDTH(4), .GROUP(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a4),
        .b     (b4),
        .sum   (sum4),
        .c_out (c4)
    );

    cla_adder #(.WIDTH(16), .GROUP(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a16),
        .b     (b16),
        .sum   (sum16),
        .c_out (c16)
    );

    typedef struct {
        logic [4:0]  e4;
        logic [16:0] e16;
        string       name;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sum;
        logic       c;
        string      name;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Drive one cycle, queue its expected results, then check after the edge.
    task automatic apply(input logic r, input logic [3:0] x4, input logic [3:0] y4,
                         input logic [4:0] e4, input logic [15:0] x16,
                         input logic [15:0] y16, input logic [16:0] e16, input string name);
        exp_t e;
        rst_n = r;
        a4    = x4;
        b4    = y4;
        a16   = x16;
        b16   = y16;
        sb.push_back('{e4: e4, e16: e16, name: name});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        if ({c4, sum4} !== e.e4) begin
            errors++;
            $display("FAIL %s w4: got c_out=%b sum=%b, want c_out=%b sum=%b",
                     e.name, c4, sum4, e.e4[4], e.e4[3:0]);
        end
        checks++;
        if ({c16, sum16} !== e.e16) begin
            errors++;
            $display("FAIL %s w16: got c_out=%b sum=%h, want c_out=%b sum=%h",
                     e.name, c16, sum16, e.e16[16], e.e16[15:0]);
        end
    endtask

    // Same as apply, but expected values come from the arithmetic reference.
    task automatic apply_ref(input logic r, input logic [3:0] x4, input logic [3:0] y4,
                             input logic [15:0] x16, input logic [15:0] y16, input string name);
        logic [4:0]  e4;
        logic [16:0] e16;
        e4  = r ? ({1'b0, x4} + {1'b0, y4}) : 5'd0;
        e16 = r ? ({1'b0, x16} + {1'b0, y16}) : 17'd0;
        apply(r, x4, y4, e4, x16, y16, e16, name);
    endtask

    vec_t vecs[12];

    initial begin
        vecs = '{
            '{1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, "rst_hold0"},
            '{1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, "rst_hold1"},
            '{1'b1, 4'b1111, 4'b1111, 4'b1110, 1'b1, "rst_release"},
            '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, "zero"},
            '{1'b1, 4'b1001, 4'b0000, 4'b1001, 1'b0, "pass_a"},
            '{1'b1, 4'b1001, 4'b0110, 4'b1111, 1'b0, "no_carry_fill"},
            '{1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b1, "full_propagate"},
            '{1'b1, 4'b0111, 4'b0001, 4'b1000, 1'b0, "propagate_to_msb"},
            '{1'b1, 4'b1111, 4'b1111, 4'b1110, 1'b1, "max_operands"},
            '{1'b1, 4'b1000, 4'b1000, 4'b0000, 1'b1, "msb_generate"},
            '{1'b0, 4'b1111, 4'b1111, 4'b0000, 1'b0, "mid_reset"},
            '{1'b1, 4'b0101, 4'b0011, 4'b1000, 1'b0, "after_mid_reset"}
        };

        // 16-bit instance sees zeros during the 4-bit directed table.
        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].a, vecs[i].b, {vecs[i].c, vecs[i].sum},
                  16'h0000, 16'h0000, 17'h00000, vecs[i].name);
        end

        for (int i = 0; i < 256; i++) begin
            logic [7:0] ab;
            ab = 8'(i);
            apply_ref(1'b1, ab[7:4], ab[3:0], 16'(i * 257), 16'(i * 131), "exhaustive");
        end

        apply(1'b1, 4'h0, 4'h0, 5'h00, 16'hFFFF, 16'h0001, 17'h10000, "w16_full_propagate");
        apply(1'b1, 4'h0, 4'h0, 5'h00, 16'h0FFF, 16'h0001, 17'h01000, "w16_group_ripple");
        apply(1'b1, 4'h0, 4'h0, 5'h00, 16'h8000, 16'h8000, 17'h10000, "w16_msb_generate");
        apply(1'b1, 4'h0, 4'h0, 5'h00, 16'h00F0, 16'h0F10, 17'h01000, "w16_mid_groups");

        for (int i = 0; i < 10000; i++) begin
            logic r;
            r = !((i % 1000) == 500 || (i % 1000) == 501);
            apply_ref(r, 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
                      r ? "random" : "random_reset");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
